// File: rtl/toggle_cdc_pkg.sv
// Shared types for both ends of the toggle-based pulse crossing.
// No logic; the enum and the default counter width are used by sender and receiver.
// No flow control here.
package toggle_cdc_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    localparam int DEFAULT_CNT_WIDTH = 4;

endpackage

// File: rtl/double_latching_barrier.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency: 2 enabled clk cycles. No backpressure; holds its state while enable is low.
module double_latching_barrier #(
    parameter bit AT_POSEDGE_RST = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic d,
    output logic q
);

    logic [1:0] sync;

    generate
        if (AT_POSEDGE_RST) begin : g_async_rst
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync <= 2'b00;
                end else if (enable) begin
                    sync <= {sync[0], d};
                end
            end
        end else begin : g_sync_rst
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync <= 2'b00;
                end else if (enable) begin
                    sync <= {sync[0], d};
                end
            end
        end
    endgenerate

    assign q = sync[1];

endmodule

// File: rtl/toggle_handshake_sender.sv
// Source end of the toggle pulse crossing: pulses become req toggles, next launch waits for ack.
// Latency: req flips 1 cycle after pulse_in; extra events queue in a saturating counter, overflow is sticky.
// Optional ack timeout flag built when TOGGLE_HANDSHAKE_SENDER_TIMEOUT_EN is defined.
module toggle_handshake_sender
    import toggle_cdc_pkg::*;
#(
    parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 pulse_in,
    input  logic                 ack_toggle_in,
    output logic                 req_toggle_out,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pending,
    output logic                 overflow,
    output logic                 timeout_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state;
    state_t               state_n;
    logic                 req_n;
    logic [CNT_WIDTH-1:0] pending_n;
    logic                 overflow_n;
    logic                 ack_sync;

    double_latching_barrier #(
        .AT_POSEDGE_RST(1'b0)
    ) u_ack_sync (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .d      (ack_toggle_in),
        .q      (ack_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            req_toggle_out <= 1'b0;
            pending        <= '0;
            overflow       <= 1'b0;
        end else if (enable) begin
            state          <= state_n;
            req_toggle_out <= req_n;
            pending        <= pending_n;
            overflow       <= overflow_n;
        end
    end

    always_comb begin
        state_n    = state;
        req_n      = req_toggle_out;
        pending_n  = pending;
        overflow_n = overflow;
        case (state)
            IDLE: begin
                if (pulse_in || (pending != '0)) begin
                    state_n = WAIT_ACK;
                    req_n   = ~req_toggle_out;
                    // A pulse arriving alongside a queued launch replaces the consumed entry.
                    if (!pulse_in) begin
                        pending_n = pending - CNT_WIDTH'(1);
                    end
                end
            end
            WAIT_ACK: begin
                if (ack_sync == req_toggle_out) begin
                    state_n = IDLE;
                end
                if (pulse_in) begin
                    if (pending == CNT_MAX) begin
                        overflow_n = 1'b1;
                    end else begin
                        pending_n = pending + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state == WAIT_ACK);

`ifdef TOGGLE_HANDSHAKE_SENDER_TIMEOUT_EN
    localparam int            TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_n;
    logic            to_flag;
    logic            to_flag_n;

    always_comb begin
        to_cnt_n  = to_cnt;
        to_flag_n = to_flag;
        if ((state == IDLE) && (state_n == WAIT_ACK)) begin
            to_cnt_n = '0;
        end else if (state == WAIT_ACK) begin
            if (to_cnt != TO_MAX) begin
                to_cnt_n = to_cnt + TO_W'(1);
            end
            if (to_cnt_n == TO_MAX) begin
                to_flag_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else if (enable) begin
            to_cnt  <= to_cnt_n;
            to_flag <= to_flag_n;
        end
    end

    assign timeout_err = to_flag;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_handshake_sender.sv
// Directed bench for toggle_handshake_sender with a 3-cycle loopback receiver and a cycle-stamped scoreboard.
// Expected snapshots are queued by the stimulus and compared by the monitor on the falling edge.
module tb_toggle_handshake_sender;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       pulse_in;
    logic       ack_toggle_in;
    logic       req_toggle_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;
    logic       timeout_err;

    logic       ack_hold;
    logic [2:0] rx_pipe;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

`ifdef TOGGLE_HANDSHAKE_SENDER_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    typedef struct {
        int         at;
        string      nm;
        logic       req;
        logic       bsy;
        logic [1:0] pnd;
        logic       ovf;
        logic       to;
    } exp_t;

    exp_t q[$];
    exp_t e;

    toggle_handshake_sender #(
        .CNT_WIDTH      (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .pulse_in       (pulse_in),
        .ack_toggle_in  (ack_toggle_in),
        .req_toggle_out (req_toggle_out),
        .busy           (busy),
        .pending        (pending),
        .overflow       (overflow),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Destination-side model: returns req three cycles later; ack_hold stalls it.
    always @(posedge clk) begin
        if (rst) begin
            rx_pipe <= 3'b000;
        end else if (!ack_hold) begin
            rx_pipe <= {rx_pipe[1:0], req_toggle_out};
        end
    end
    assign ack_toggle_in = rx_pipe[2];

    always @(negedge clk) begin
        while ((q.size() > 0) && (q[0].at <= cyc)) begin
            e = q.pop_front();
            n_checks++;
            if (e.at < cyc) begin
                n_fail++;
                $display("FAIL %s: snapshot for cycle %0d missed at cycle %0d", e.nm, e.at, cyc);
            end else if ((req_toggle_out !== e.req) || (busy !== e.bsy) || (pending !== e.pnd) ||
                         (overflow !== e.ovf) || (timeout_err !== e.to)) begin
                n_fail++;
                $display("FAIL %s @%0d: got req=%b busy=%b pend=%0d ovf=%b to=%b, want req=%b busy=%b pend=%0d ovf=%b to=%b",
                         e.nm, cyc, req_toggle_out, busy, pending, overflow, timeout_err,
                         e.req, e.bsy, e.pnd, e.ovf, e.to);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ex(input int at, input string nm, input logic r, input logic b,
                      input logic [1:0] p, input logic o, input logic t);
        exp_t x;
        x.at  = at;
        x.nm  = nm;
        x.req = r;
        x.bsy = b;
        x.pnd = p;
        x.ovf = o;
        x.to  = t;
        q.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        rst      = 1'b1;
        enable   = 1'b1;
        pulse_in = 1'b0;
        ack_hold = 1'b0;
        tick(3);
        ex(cyc, "reset", 0, 0, 2'd0, 0, 0);
        rst = 1'b0;
        tick(3);

        // single event
        n = cyc;
        pulse_in = 1'b1;
        ex(n + 1, "single_launch", 1, 1, 2'd0, 0, 0);
        ex(n + 6, "single_wait",   1, 1, 2'd0, 0, 0);
        ex(n + 7, "single_done",   1, 0, 2'd0, 0, 0);
        tick(1);
        pulse_in = 1'b0;
        tick(9);

        // burst of four back-to-back pulses
        n = cyc;
        pulse_in = 1'b1;
        ex(n + 1,  "burst_launch1", 0, 1, 2'd0, 0, 0);
        ex(n + 4,  "burst_queued",  0, 1, 2'd3, 0, 0);
        ex(n + 7,  "burst_done1",   0, 0, 2'd3, 0, 0);
        ex(n + 8,  "burst_launch2", 1, 1, 2'd2, 0, 0);
        ex(n + 14, "burst_done2",   1, 0, 2'd2, 0, 0);
        ex(n + 15, "burst_launch3", 0, 1, 2'd1, 0, 0);
        ex(n + 21, "burst_done3",   0, 0, 2'd1, 0, 0);
        ex(n + 22, "burst_launch4", 1, 1, 2'd0, 0, 0);
        ex(n + 28, "burst_idle",    1, 0, 2'd0, 0, 0);
        tick(4);
        pulse_in = 1'b0;
        tick(26);

        // pulse in completion cycle, then pulse in IDLE with pending=2
        n = cyc;
        pulse_in = 1'b1;
        ex(n + 3,  "simul_pend2",      0, 1, 2'd2, 0, 0);
        ex(n + 7,  "simul_cmpl_pulse", 0, 0, 2'd3, 0, 0);
        ex(n + 8,  "simul_relaunch",   1, 1, 2'd2, 0, 0);
        ex(n + 14, "simul_idle_p2",    1, 0, 2'd2, 0, 0);
        ex(n + 15, "simul_idle_pulse", 0, 1, 2'd2, 0, 0);
        ex(n + 22, "simul_launch_p1",  1, 1, 2'd1, 0, 0);
        ex(n + 29, "simul_launch_p0",  0, 1, 2'd0, 0, 0);
        ex(n + 35, "simul_drained",    0, 0, 2'd0, 0, 0);
        tick(3);
        pulse_in = 1'b0;
        tick(3);
        pulse_in = 1'b1;
        tick(1);
        pulse_in = 1'b0;
        tick(7);
        pulse_in = 1'b1;
        tick(1);
        pulse_in = 1'b0;
        tick(22);

        // pulse ignored while disabled
        n = cyc;
        enable   = 1'b0;
        pulse_in = 1'b1;
        ex(n + 1, "disabled_1", 0, 0, 2'd0, 0, 0);
        ex(n + 2, "disabled_2", 0, 0, 2'd0, 0, 0);
        ex(n + 4, "disabled_after", 0, 0, 2'd0, 0, 0);
        tick(2);
        pulse_in = 1'b0;
        tick(1);
        enable = 1'b1;
        tick(2);

        // enable low in WAIT_ACK freezes the ack synchronizer
        n = cyc;
        pulse_in = 1'b1;
        ex(n + 1, "freeze_launch", 1, 1, 2'd0, 0, 0);
        ex(n + 3, "freeze_held",   1, 1, 2'd0, 0, 0);
        ex(n + 7, "freeze_late",   1, 1, 2'd0, 0, 0);
        ex(n + 8, "freeze_done",   1, 0, 2'd0, 0, 0);
        tick(1);
        pulse_in = 1'b0;
        enable   = 1'b0;
        tick(4);
        enable = 1'b1;
        tick(5);

        // reset while waiting with two events queued
        n = cyc;
        pulse_in = 1'b1;
        ex(n + 3, "rst_pre", 0, 1, 2'd2, 0, 0);
        tick(3);
        pulse_in = 1'b0;
        rst      = 1'b1;
        ex(n + 4, "rst_clear", 0, 0, 2'd0, 0, 0);
        tick(1);
        rst = 1'b0;
        ex(n + 6, "rst_stays", 0, 0, 2'd0, 0, 0);
        tick(4);

        // saturation with ack held off
        n = cyc;
        ack_hold = 1'b1;
        pulse_in = 1'b1;
        ex(n + 1,  "sat_launch",  1, 1, 2'd0, 0, 0);
        ex(n + 4,  "sat_full",    1, 1, 2'd3, 0, 0);
        ex(n + 5,  "sat_drop",    1, 1, 2'd3, 1, 0);
        ex(n + 8,  "sat_hold",    1, 1, 2'd3, 1, 0);
        ex(n + 14, "sat_done1",   1, 0, 2'd3, 1, 0);
        ex(n + 15, "sat_launch2", 0, 1, 2'd2, 1, 0);
        ex(n + 22, "sat_launch3", 1, 1, 2'd1, 1, 0);
        ex(n + 29, "sat_launch4", 0, 1, 2'd0, 1, 0);
        ex(n + 35, "sat_idle",    0, 0, 2'd0, 1, 0);
        ex(n + 40, "sat_quiet",   0, 0, 2'd0, 1, 0);
        tick(5);
        pulse_in = 1'b0;
        tick(3);
        ack_hold = 1'b0;
        tick(33);

        // ack never returns
        n = cyc;
        ack_hold = 1'b1;
        pulse_in = 1'b1;
        ex(n + 1,  "to_launch", 1, 1, 2'd0, 1, 0);
        ex(n + 8,  "to_before", 1, 1, 2'd0, 1, 0);
        ex(n + 9,  "to_flag",   1, 1, 2'd0, 1, TO_EXP);
        ex(n + 15, "to_sticky", 1, 1, 2'd0, 1, TO_EXP);
        tick(1);
        pulse_in = 1'b0;
        tick(16);

        for (int i = 0; (i < 50) && (q.size() > 0); i++) begin
            tick(1);
        end
        n_checks++;
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d snapshots left, required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
